regfile_hazard_scoreboard: RTL

Tracks in-flight register writes for the 5-stage pipeline (IF, ID, EX, MEM, WB) and decides two things for each instruction in ID. First, whether it must stall on a load-use hazard. Second, which forwarding source each of its two operands will use once it reaches EX. It sits beside the ID/EX pipeline register and is the read-side counterpart of the register file's write port. It consumes decoded source and destination fields and produces the stall signal and registered forwarding selects for the EX-stage operand muxes.

---
 rtl/regfile_hazard_scoreboard.sv | 68 ++++++
 1 files changed

// File: rtl/regfile_hazard_scoreboard.sv
// regfile_hazard_scoreboard: tracks in-flight writes in EX/MEM/WB, raises load-use stall
// and registers per-operand forwarding selects for the instruction entering EX.
module regfile_hazard_scoreboard #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   input  logic              id_useRs1,
   input  logic              id_useRs2,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic              id_regWrite,
   input  logic              id_memRead,
   input  logic              flush,
   output logic              stall,
   output logic [1:0]        fwdA,
   output logic [1:0]        fwdB,
   output logic              ex_busy,
   output logic              mem_busy,
   output logic              wb_busy
);
   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] dest;
      logic              wr;
      logic              ld;
   } slot_t;
   slot_t ex_q, ex_d, mem_q;
   logic wb_q;
   logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic ex_wr, mem_wr, a_ex, b_ex, a_mem, b_mem, bubble;
   always_comb begin
      ex_wr   = ex_q.valid & ex_q.wr & (ex_q.dest != '0);
      mem_wr  = mem_q.valid & mem_q.wr & (mem_q.dest != '0);
      a_ex    = id_useRs1 & (ReadReg1 != '0) & ex_wr & (ex_q.dest == ReadReg1);
      b_ex    = id_useRs2 & (ReadReg2 != '0) & ex_wr & (ex_q.dest == ReadReg2);
      a_mem   = id_useRs1 & (ReadReg1 != '0) & mem_wr & (mem_q.dest == ReadReg1);
      b_mem   = id_useRs2 & (ReadReg2 != '0) & mem_wr & (mem_q.dest == ReadReg2);
      stall   = id_valid & ~flush & (a_ex | b_ex) & ex_q.ld;
      bubble  = ~id_valid | stall | flush;
      ex_d    = bubble ? '0 : slot_t'{1'b1, WriteReg, id_regWrite, id_memRead};
      // an EX match here is never a load: that case stalled and became a bubble
      fwd_a_d = bubble ? 2'b00 : a_ex ? 2'b01 : a_mem ? 2'b10 : 2'b00;
      fwd_b_d = bubble ? 2'b00 : b_ex ? 2'b01 : b_mem ? 2'b10 : 2'b00;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= 1'b0;
         fwd_a_q <= 2'b00;
         fwd_b_q <= 2'b00;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= ex_q;
         wb_q    <= mem_q.valid;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end
   assign fwdA     = fwd_a_q;
   assign fwdB     = fwd_b_q;
   assign ex_busy  = ex_q.valid;
   assign mem_busy = mem_q.valid;
   assign wb_busy  = wb_q;
endmodule
